// File: rtl/wb_multi_stage.sv
// Writeback stage: multi-lane RF writeback with same-register masking
// and a serialising debug trace queue that emits one write per cycle.
module wb_multi_stage #(
  parameter int LANES       = 2,
  parameter int DATA_W      = 32,
  parameter int RADDR_W     = 5,
  parameter int PC_W        = 32,
  parameter int TRACE_DEPTH = 4,
  parameter int STALL_W     = 6,
  parameter int STAGE       = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [STALL_W-1:0]                        stall,
  input  logic [LANES*(PC_W+1+RADDR_W+DATA_W)-1:0]  mem_to_wb_bus,
  input  logic [2*LANES-1:0]                        hilo_mem_to_wb_bus,
  output logic [LANES*(1+RADDR_W+DATA_W)-1:0]       wb_to_rf_bus,
  output logic [2*LANES-1:0]                        hilo_wb_to_rf_bus,
  output logic [PC_W-1:0]                           debug_wb_pc,
  output logic [3:0]                                debug_wb_rf_wen,
  output logic [RADDR_W-1:0]                        debug_wb_rf_wnum,
  output logic [DATA_W-1:0]                         debug_wb_rf_wdata,
  output logic                                      trace_stall_req,
  output logic [$clog2(TRACE_DEPTH+1)-1:0]          trace_count,
  output logic                                      trace_overflow
);

  localparam int LW = PC_W + 1 + RADDR_W + DATA_W;
  localparam int OW = 1 + RADDR_W + DATA_W;
  localparam int CW = $clog2(TRACE_DEPTH + 1);
  localparam int PW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [RADDR_W-1:0] wnum;
    logic [DATA_W-1:0]  wdata;
  } ent_t;

  logic [LANES*LW-1:0] stage_q, stage_d;
  logic [2*LANES-1:0]  hilo_q, hilo_d;
  logic                pend_q, pend_d;
  logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]       count_q, count_d;
  ent_t                dbg_q, dbg_d;
  logic                dbg_v_q, dbg_v_d;
  logic                ovf_q;
  ent_t                fifo_q [TRACE_DEPTH];

  logic [LANES-1:0]    l_we, rf_we, enq_en;
  ent_t                l_ent   [LANES];
  logic [PW-1:0]       enq_idx [LANES];
  logic                pop, drop;
  logic                unused_stall;

  assign unused_stall = ^stall;

  always_comb begin
    stage_d = stage_q;
    hilo_d  = hilo_q;
    pend_d  = 1'b0;
    if (stall[STAGE] == NOSTOP) begin
      stage_d = mem_to_wb_bus;
      hilo_d  = hilo_mem_to_wb_bus;
      pend_d  = 1'b1;
    end else if (stall[STAGE+1] == NOSTOP) begin
      stage_d = '0;
      hilo_d  = '0;
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      l_we[l]  = stage_q[l*LW+DATA_W+RADDR_W];
      l_ent[l] = ent_t'({stage_q[l*LW+DATA_W+RADDR_W+1 +: PC_W],
                         stage_q[l*LW+DATA_W +: RADDR_W],
                         stage_q[l*LW +: DATA_W]});
    end
  end

  // Younger lane wins a same-register conflict
  always_comb begin
    rf_we = l_we;
    for (int i = 0; i < LANES; i++)
      for (int j = i + 1; j < LANES; j++)
        if (l_we[j] && l_ent[j].wnum == l_ent[i].wnum)
          rf_we[i] = 1'b0;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign wb_to_rf_bus[g*OW +: OW] =
      {rf_we[g], l_ent[g].wnum, l_ent[g].wdata};
  end
  assign hilo_wb_to_rf_bus = hilo_q;

  // Head pops first; with an empty queue the oldest push bypasses it
  always_comb begin
    int  free;
    int  nenq;
    int  idx;
    logic byp;
    pop     = (count_q != '0);
    enq_en  = '0;
    drop    = 1'b0;
    byp     = 1'b0;
    nenq    = 0;
    idx     = 0;
    dbg_v_d = pop;
    dbg_d   = pop ? fifo_q[rd_q] : '0;
    for (int l = 0; l < LANES; l++) enq_idx[l] = '0;
    free = TRACE_DEPTH - int'(count_q) + int'(pop);
    for (int l = 0; l < LANES; l++) begin
      if (pend_q && l_we[l]) begin
        if (!pop && !byp) begin
          byp     = 1'b1;
          dbg_v_d = 1'b1;
          dbg_d   = l_ent[l];
        end else if (nenq < free) begin
          idx = int'(wr_q) + nenq;
          if (idx >= TRACE_DEPTH) idx = idx - TRACE_DEPTH;
          enq_en[l]  = 1'b1;
          enq_idx[l] = PW'(idx);
          nenq       = nenq + 1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    idx = int'(wr_q) + nenq;
    if (idx >= TRACE_DEPTH) idx = idx - TRACE_DEPTH;
    wr_d = PW'(idx);
    idx = int'(rd_q) + int'(pop);
    if (idx >= TRACE_DEPTH) idx = idx - TRACE_DEPTH;
    rd_d    = PW'(idx);
    count_d = CW'(int'(count_q) + nenq - int'(pop));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
      hilo_q  <= '0;
      pend_q  <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      dbg_q   <= '0;
      dbg_v_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      stage_q <= stage_d;
      hilo_q  <= hilo_d;
      pend_q  <= pend_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      dbg_q   <= dbg_d;
      dbg_v_q <= dbg_v_d;
      ovf_q   <= ovf_q | drop;
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++)
      if (enq_en[l]) fifo_q[enq_idx[l]] <= l_ent[l];
  end

  assign debug_wb_pc       = dbg_q.pc;
  assign debug_wb_rf_wen   = {4{dbg_v_q}};
  assign debug_wb_rf_wnum  = dbg_q.wnum;
  assign debug_wb_rf_wdata = dbg_q.wdata;
  assign trace_count       = count_q;
  assign trace_overflow    = ovf_q;
  assign trace_stall_req   = (TRACE_DEPTH - int'(count_q)) < LANES;

endmodule

// File: tb/tb_wb_multi_stage.sv
// Scoreboard bench for wb_multi_stage: directed vectors push expected
// trace entries; a negedge monitor pops and compares debug outputs.
module tb_wb_multi_stage;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall;
  logic [139:0]  mem_bus;
  logic [3:0]    hilo_in;
  logic [75:0]   rf_bus;
  logic [3:0]    hilo_out;
  logic [31:0]   dpc;
  logic [3:0]    dwen;
  logic [4:0]    dwnum;
  logic [31:0]   dwdata;
  logic          sreq;
  logic [2:0]    tcnt;
  logic          ovf;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  n;
    logic [31:0] d;
  } tr_t;

  tr_t exp_q[$];
  tr_t mon_e;
  int  n_chk  = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  wb_multi_stage #(
    .LANES(2), .DATA_W(32), .RADDR_W(5), .PC_W(32),
    .TRACE_DEPTH(4), .STALL_W(6), .STAGE(4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .mem_to_wb_bus      (mem_bus),
    .hilo_mem_to_wb_bus (hilo_in),
    .wb_to_rf_bus       (rf_bus),
    .hilo_wb_to_rf_bus  (hilo_out),
    .debug_wb_pc        (dpc),
    .debug_wb_rf_wen    (dwen),
    .debug_wb_rf_wnum   (dwnum),
    .debug_wb_rf_wdata  (dwdata),
    .trace_stall_req    (sreq),
    .trace_count        (tcnt),
    .trace_overflow     (ovf)
  );

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [69:0] ln(logic [31:0] pc, logic we,
                                     logic [4:0] a, logic [31:0] d);
    return {pc, we, a, d};
  endfunction

  function automatic logic [37:0] ol(logic we, logic [4:0] a,
                                     logic [31:0] d);
    return {we, a, d};
  endfunction

  task automatic ex(logic [31:0] pc, logic [4:0] a, logic [31:0] d);
    tr_t t;
    t.pc = pc;
    t.n  = a;
    t.d  = d;
    exp_q.push_back(t);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    mem_bus = '0;
    hilo_in = '0;
    stall   = '0;
    repeat (n) cyc();
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && dwen !== 4'h0) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL trace_unexpected: got pc %h wnum %0d wdata %h expected none",
                 dpc, dwnum, dwdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("trace_wen", dwen, 4'hF);
        chk("trace_pc", dpc, mon_e.pc);
        chk("trace_wnum", dwnum, mon_e.n);
        chk("trace_wdata", dwdata, mon_e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    stall   = '0;
    mem_bus = '0;
    hilo_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf", rf_bus, '0);
    chk("rst_hilo", hilo_out, '0);
    chk("rst_dbg", {dpc, dwen, dwnum, dwdata}, '0);
    chk("rst_flags", {ovf, sreq, tcnt}, '0);
    rst = 1'b0;

    // single write, latency
    mem_bus = {ln(32'hBFC00004, 0, 0, 0), ln(32'hBFC00000, 1, 3, 32'h11)};
    ex(32'hBFC00000, 3, 32'h11);
    cyc();
    chk("t1_rf", rf_bus, {ol(0, 0, 0), ol(1, 3, 32'h11)});
    chk("t1_wen_early", dwen, 4'h0);
    mem_bus = '0;
    cyc();
    chk("t1_wen_lat", dwen, 4'hF);
    idle(2);

    // dual write to same register
    mem_bus = {ln(32'h104, 1, 8, 32'hB), ln(32'h100, 1, 8, 32'hA)};
    hilo_in = 4'b1001;
    ex(32'h100, 8, 32'hA);
    ex(32'h104, 8, 32'hB);
    cyc();
    chk("t2_rf_mask", rf_bus, {ol(1, 8, 32'hB), ol(0, 8, 32'hA)});
    chk("t2_hilo", hilo_out, 4'b1001);
    idle(3);

    // bubble
    mem_bus = {ln(0, 0, 0, 0), ln(32'h200, 1, 5, 32'h55)};
    hilo_in = 4'b0011;
    ex(32'h200, 5, 32'h55);
    cyc();
    chk("t3_hilo_load", hilo_out, 4'b0011);
    stall   = 6'b010000;
    mem_bus = {ln(32'h240, 1, 6, 32'h66), ln(32'h23C, 1, 7, 32'h77)};
    hilo_in = 4'hF;
    cyc();
    chk("t3_bub_rf", rf_bus, '0);
    chk("t3_bub_hilo", hilo_out, '0);
    cyc();
    chk("t3_bub_notrace", dwen, 4'h0);
    chk("t3_bub_cnt", tcnt, 3'd0);
    idle(1);

    // address 0 write passes through
    mem_bus = {ln(0, 0, 0, 0), ln(32'h300, 1, 0, 32'h77)};
    ex(32'h300, 0, 32'h77);
    cyc();
    chk("t4_rf_a0", rf_bus, {ol(0, 0, 0), ol(1, 0, 32'h77)});
    idle(3);

    // hold for 3 cycles
    mem_bus = {ln(32'h404, 1, 2, 32'h22), ln(32'h400, 1, 1, 32'h21)};
    hilo_in = 4'b0110;
    ex(32'h400, 1, 32'h21);
    ex(32'h404, 2, 32'h22);
    cyc();
    stall   = 6'b110000;
    mem_bus = {ln(32'hDEAD, 1, 7, 32'h6666), ln(32'hBEEF, 1, 7, 32'h7777)};
    hilo_in = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t5_hold_rf", rf_bus, {ol(1, 2, 32'h22), ol(1, 1, 32'h21)});
      chk("t5_hold_hilo", hilo_out, 4'b0110);
    end
    idle(3);

    // back-to-back dual writes, overflow
    for (int k = 1; k <= 6; k++) begin
      mem_bus = {ln(32'h1004 + 32'(k*8), 1, 5'(k+10), 32'hB0 + 32'(k)),
                 ln(32'h1000 + 32'(k*8), 1, 5'(k), 32'hA0 + 32'(k))};
      ex(32'h1000 + 32'(k*8), 5'(k), 32'hA0 + 32'(k));
      if (k < 5) ex(32'h1004 + 32'(k*8), 5'(k+10), 32'hB0 + 32'(k));
      cyc();
      case (k)
        3: begin
          chk("t6_cnt2", tcnt, 3'd2);
          chk("t6_sreq_lo", sreq, 1'b0);
        end
        4: begin
          chk("t6_cnt3", tcnt, 3'd3);
          chk("t6_sreq_hi", sreq, 1'b1);
        end
        5: begin
          chk("t6_cnt4", tcnt, 3'd4);
          chk("t6_ovf_lo", ovf, 1'b0);
        end
        6: begin
          chk("t6_ovf_hi", ovf, 1'b1);
          chk("t6_cnt4b", tcnt, 3'd4);
        end
        default: ;
      endcase
    end
    mem_bus = '0;
    cyc();
    chk("t6_cnt_full", tcnt, 3'd4);
    idle(5);
    chk("t6_drained", tcnt, 3'd0);
    chk("t6_ovf_sticky", ovf, 1'b1);

    // reset with 3 queued entries
    ex(32'h2008, 17, 32'hC1);
    ex(32'h200C, 21, 32'hD1);
    ex(32'h2010, 18, 32'hC2);
    for (int k = 1; k <= 3; k++) begin
      mem_bus = {ln(32'h2004 + 32'(k*8), 1, 5'(k+20), 32'hD0 + 32'(k)),
                 ln(32'h2000 + 32'(k*8), 1, 5'(k+16), 32'hC0 + 32'(k))};
      cyc();
    end
    mem_bus = {ln(0, 0, 0, 0), ln(32'h2100, 1, 30, 32'h123)};
    hilo_in = 4'hF;
    cyc();
    chk("t7_cnt3", tcnt, 3'd3);
    chk("t7_rf_pre", rf_bus, {ol(0, 0, 0), ol(1, 30, 32'h123)});
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t7_rst_rf", rf_bus, '0);
    chk("t7_rst_hilo", hilo_out, '0);
    chk("t7_rst_dbg", {dpc, dwen, dwnum, dwdata}, '0);
    chk("t7_rst_flags", {ovf, sreq, tcnt}, '0);
    mem_bus = '0;
    hilo_in = '0;
    stall   = '0;
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    chk("t7_cnt_post", tcnt, 3'd0);

    // first load after reset
    mem_bus = {ln(0, 0, 0, 0), ln(32'h500, 1, 9, 32'h99)};
    ex(32'h500, 9, 32'h99);
    cyc();
    chk("t8_rf", rf_bus, {ol(0, 0, 0), ol(1, 9, 32'h99)});
    idle(3);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_multi_stage.md
WB_MULTI_STAGE -- requirements
Module: wb_multi_stage

Interface
REQ-001 SHALL have parameters: LANES, default 2, writeback lanes (lane 0 oldest); DATA_W, default 32, register data width; RADDR_W, default 5, register address width; PC_W, default 32, PC width; TRACE_DEPTH, default 4, debug trace queue entries (must be >= LANES); STALL_W, default 6, stall bus width; STAGE, default 4, this stage's stall bit index.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- stall  in  STALL_W  pipeline stall bus; `Stop`/`NoStop` encodings from defines.vh.
- mem_to_wb_bus  in  LANES*(PC_W+1+RADDR_W+DATA_W)  per lane {pc, rf_we, rf_waddr, rf_wdata}; lane 0 in the LSBs.
- hilo_mem_to_wb_bus  in  2*LANES  per lane {hi_we, lo_we}.
- wb_to_rf_bus  out  LANES*(1+RADDR_W+DATA_W)  per lane {rf_we, rf_waddr, rf_wdata}.
- hilo_wb_to_rf_bus  out  2*LANES  registered per-lane {hi_we, lo_we}.
- debug_wb_pc  out  PC_W  serialized trace PC.
- debug_wb_rf_wen  out  4  trace write enable, replicated.
- debug_wb_rf_wnum  out  RADDR_W  trace register number.
- debug_wb_rf_wdata  out  DATA_W  trace write data.
- trace_stall_req  out  1  trace queue near-full; asks the stall controller to stop MEM.
- trace_count  out  clog2(TRACE_DEPTH+1)  queue occupancy.
- trace_overflow  out  1  sticky: a trace entry was dropped.

Function
REQ-004 Stage register SHALL update on each posedge clk as follows:
- stall[STAGE]=Stop and stall[STAGE+1]=NoStop: load all zeros (bubble).
- stall[STAGE]=NoStop: load mem_to_wb_bus and hilo_mem_to_wb_bus.
- stall[STAGE]=Stop and stall[STAGE+1]=Stop: hold.
REQ-005 wb_to_rf_bus and hilo_wb_to_rf_bus SHALL be combinational from the stage register, with zero added latency.
REQ-006 Same-register conflict: if lanes i<j both have rf_we=1 and equal rf_waddr, lane i's rf_we SHALL be masked to 0 on wb_to_rf_bus. The youngest lane wins. Both lanes SHALL still be traced.
REQ-007 Address 0 writes SHALL pass to wb_to_rf_bus unchanged; the register file ignores them. They SHALL be traced.
REQ-008 A "pending" flag SHALL be set when the stage register loads, and cleared at the first edge at which its lanes are pushed to the trace queue. A held register SHALL NOT be traced twice.
REQ-009 Trace push: at each edge with pending=1, every lane with rf_we=1 SHALL be enqueued in ascending lane order. Zero to LANES pushes per edge.
REQ-010 Trace pop: at each edge, the queue head (or, if the queue is empty, the oldest lane being pushed that edge, as a bypass) SHALL load the debug output registers with debug_wb_rf_wen=4'b1111. With no entry available, debug_wb_rf_wen SHALL be 4'b0000 and pc/wnum/wdata SHALL be 0.
REQ-011 Trace latency SHALL be: a single write appears on debug_* exactly one cycle after it becomes visible on wb_to_rf_bus. Subsequent same-cycle lanes follow on consecutive cycles, in order.
REQ-012 Push and pop at the same edge SHALL be allowed. Occupancy SHALL equal the previous occupancy plus pushes minus pops, with pointers wrapping modulo TRACE_DEPTH.
REQ-013 trace_stall_req SHALL be combinational and high when TRACE_DEPTH - trace_count < LANES.
REQ-014 Pushes exceeding free space after the same-edge pop SHALL be dropped, youngest lanes first, and SHALL set trace_overflow. The flag is cleared only by rst.
REQ-015 trace_stall_req SHALL NOT alter RF writeback; only the external stall bus controls the stage register.

Reset
REQ-016 rst SHALL asynchronously clear:
- the stage register, so all wb_to_rf_bus and hilo outputs are 0;
- pending, the queue pointers and trace_count;
- all debug_* outputs and trace_overflow.
REQ-017 Reset mid-operation SHALL discard queued trace entries without emitting them. The first edge after release SHALL behave as in REQ-004.

Verification
REQ-018 Load, no stall: lane0 {pc=0xBFC00000, we=1, waddr=3, wdata=0x11}, lane1 we=0 -> RF sees lane0 the next cycle; debug shows pc 0xBFC00000, wen F, wnum 3, wdata 0x11 one cycle later.
REQ-019 Dual write to waddr 8 (lane0 wdata=0xA, lane1 wdata=0xB) -> RF lane0 we=0 and lane1 we=1 with 0xB; debug shows 0xA then 0xB on consecutive cycles.
REQ-020 stall[4]=Stop, stall[5]=NoStop -> stage register all zero; RF we=0, hilo=0; no trace push.
REQ-021 stall[4]=Stop, stall[5]=Stop for 3 cycles on a dual-write instruction -> RF outputs held constant; exactly 2 trace entries emitted.
REQ-022 Back-to-back dual writes every cycle, TRACE_DEPTH=4 -> trace_stall_req rises when trace_count=3; with the stall ignored, trace_overflow sets; retained entries emerge in order with wrap-around.
REQ-023 Assert rst with trace_count=3 -> all outputs 0 immediately; no queued entry is emitted after release.
